// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round controller slice: the controller FSM
// state encoding, the default round count, the width of the round and
// round-key index buses, and the helper that maps a round number onto the
// key-schedule index for either direction.
//
// Ports: none (package).
// Optional feature macro used by the slice: AES_ROUND_CTRL_DECRYPT_EN.
// ----------------------------------------------------------------------------
package aes_pkg;

    // Round count used when the controller is instantiated without NR.
    localparam int AES_NR_DEFAULT = 10;

    // Width of the round number and round-key index (covers 0..14).
    localparam int AES_CNT_W = 4;

    typedef logic [AES_CNT_W-1:0] round_t;

    // Controller sequence: wait, load the input block, middle rounds,
    // final round without mixcolumns, one-cycle completion.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } aes_state_t;

    // Encryption walks the key schedule forwards; decryption walks it
    // backwards, so the key index is mirrored around the round count.
    function automatic round_t keyIndex(input round_t rnd, input round_t nr, input logic mode);
        return mode ? round_t'(nr - rnd) : rnd;
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// ----------------------------------------------------------------------------
// aes_round_ctrl_if
// Groups the request/handshake inputs and datapath-control outputs of the
// AES round controller.
//
// Signals:
//   start, decrypt, key_valid        requests into the controller
//   busy, done                       controller status
//   round, key_idx                   current round and requested key index
//   load_in, sub_en, mix_en,
//   state_we, inv                    datapath steering
//
// Modports:
//   master  the controller side (drives status and datapath controls)
//   slave   the requester / key schedule / datapath side
// ----------------------------------------------------------------------------
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic   start;
    logic   decrypt;
    logic   key_valid;
    logic   busy;
    logic   done;
    round_t round;
    round_t key_idx;
    logic   load_in;
    logic   sub_en;
    logic   mix_en;
    logic   state_we;
    logic   inv;

    modport master (
        input  start, decrypt, key_valid,
        output busy, done, round, key_idx,
        output load_in, sub_en, mix_en, state_we, inv
    );

    modport slave (
        output start, decrypt, key_valid,
        input  busy, done, round, key_idx,
        input  load_in, sub_en, mix_en, state_we, inv
    );

endinterface

// File: rtl/aes_round_cnt.sv
// ----------------------------------------------------------------------------
// aes_round_cnt
// Round counter for the AES round controller. Clears to 0, increments by one
// when asked, holds otherwise, and saturates at NR so it can never wrap.
// Also produces the round-key index: the round itself when encrypting, and
// NR minus the round when decrypting.
//
// Parameters:
//   NR         rounds per block (2..14)
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   i_clr      force the round to 0
//   i_inc      advance the round by one (saturating)
//   i_mode     1 = decrypt key ordering, 0 = encrypt
//   o_round    current round number
//   o_keyIdx   key-schedule index for the current round
// ----------------------------------------------------------------------------
module aes_round_cnt
    import aes_pkg::*;
#(
    parameter int NR = AES_NR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_clr,
    input  logic   i_inc,
    input  logic   i_mode,
    output round_t o_round,
    output round_t o_keyIdx
);

    localparam round_t LP_NR = round_t'(NR);

    round_t r_round;

    // Round register: clear has priority over increment, and the increment
    // is suppressed once NR is reached so the counter parks there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_round <= '0;
        end else if (i_clr) begin
            r_round <= '0;
        end else if (i_inc && (r_round != LP_NR)) begin
            r_round <= r_round + round_t'(1);
        end
    end

    assign o_round  = r_round;
    assign o_keyIdx = keyIndex(r_round, LP_NR, i_mode);

endmodule

// File: rtl/aes_round_ctrl.sv
// ----------------------------------------------------------------------------
// aes_round_ctrl
// Sequencer for an iterative AES datapath. After an accepted start it loads
// the input block (round 0), runs NR-1 full rounds, then a final round with
// mixcolumns bypassed, and pulses done for one cycle. Every step waits for
// the key schedule to present the requested round key (key_valid); while it
// is absent, the sequence stalls and the state register is not written.
//
// Optional feature: AES_ROUND_CTRL_DECRYPT_EN
//   defined   - decrypt is latched on start; key indices run NR..0 and inv
//               follows the latched direction while a block is in flight.
//   undefined - decrypt is ignored; the controller only encrypts, inv = 0.
//
// Parameters:
//   NR        rounds per block (2..14, default 10)
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset (aborts any block in flight)
//   bus       aes_round_ctrl_if.master - requests, status, datapath controls
// ----------------------------------------------------------------------------
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_round_ctrl_if.master bus
);

    localparam round_t LP_LAST_MID = round_t'(NR - 1);

    if ((NR < 2) || (NR > 14)) begin : g_badNr
        $error("aes_round_ctrl: NR must be in 2..14");
    end

    aes_state_t r_state;
    aes_state_t w_nextState;
    logic       r_mode;

    round_t w_cntRound;
    round_t w_cntKeyIdx;
    logic   w_cntClr;
    logic   w_cntInc;

    logic   w_busy;
    logic   w_done;
    round_t w_round;
    round_t w_keyIdx;
    logic   w_loadIn;
    logic   w_subEn;
    logic   w_mixEn;
    logic   w_stateWe;
    logic   w_inv;

    // State register. A reset on any edge returns to IDLE, which also makes
    // every decoded output 0 on the following cycle and discards the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

`ifdef AES_ROUND_CTRL_DECRYPT_EN
    // Direction flag, captured only together with an accepted start so a
    // change on decrypt mid-block has no effect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_mode <= bus.decrypt;
        end
    end
`else
    logic w_unusedDecrypt;

    assign w_unusedDecrypt = bus.decrypt;
    assign r_mode          = 1'b0;
`endif

    aes_round_cnt #(
        .NR (NR)
    ) u_roundCnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_cntClr),
        .i_inc    (w_cntInc),
        .i_mode   (r_mode),
        .o_round  (w_cntRound),
        .o_keyIdx (w_cntKeyIdx)
    );

    // Next-state logic. Every working state advances only when the round key
    // it asked for is present; ROUND leaves for FINAL when the last full round
    // (NR-1) completes, so FINAL always runs with round = NR.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_nextState = LOAD;
            LOAD:    if (bus.key_valid) w_nextState = ROUND;
            ROUND:   if (bus.key_valid && (w_cntRound == LP_LAST_MID)) w_nextState = FINAL;
            FINAL:   if (bus.key_valid) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output decode. The round counter is cleared in IDLE and DONE so each
    // block starts from round 0, and advances on each consumed key in LOAD
    // and ROUND. Round and key index are forced to 0 in IDLE because the
    // decrypt mapping would otherwise show NR there.
    always_comb begin
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_round   = '0;
        w_keyIdx  = '0;
        w_loadIn  = 1'b0;
        w_subEn   = 1'b0;
        w_mixEn   = 1'b0;
        w_stateWe = 1'b0;
        w_inv     = 1'b0;
        w_cntClr  = 1'b0;
        w_cntInc  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cntClr = 1'b1;
            end
            LOAD: begin
                w_busy    = 1'b1;
                w_round   = w_cntRound;
                w_keyIdx  = w_cntKeyIdx;
                w_loadIn  = 1'b1;
                w_stateWe = bus.key_valid;
                w_inv     = r_mode;
                w_cntInc  = bus.key_valid;
            end
            ROUND: begin
                w_busy    = 1'b1;
                w_round   = w_cntRound;
                w_keyIdx  = w_cntKeyIdx;
                w_subEn   = 1'b1;
                w_mixEn   = 1'b1;
                w_stateWe = bus.key_valid;
                w_inv     = r_mode;
                w_cntInc  = bus.key_valid;
            end
            FINAL: begin
                w_busy    = 1'b1;
                w_round   = w_cntRound;
                w_keyIdx  = w_cntKeyIdx;
                w_subEn   = 1'b1;
                w_stateWe = bus.key_valid;
                w_inv     = r_mode;
            end
            DONE: begin
                w_busy   = 1'b1;
                w_done   = 1'b1;
                w_round  = w_cntRound;
                w_keyIdx = w_cntKeyIdx;
                w_cntClr = 1'b1;
            end
            default: begin
                w_cntClr = 1'b1;
            end
        endcase
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.round    = w_round;
    assign bus.key_idx  = w_keyIdx;
    assign bus.load_in  = w_loadIn;
    assign bus.sub_en   = w_subEn;
    assign bus.mix_en   = w_mixEn;
    assign bus.state_we = w_stateWe;
    assign bus.inv      = w_inv;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_round_ctrl
// Scoreboard bench for aes_round_ctrl. The driver issues blocks with random
// key_valid stall patterns, random direction and stray start pulses; for each
// block it pushes the expected sequence of state-register writes and the
// expected done cycle. A monitor on the falling edge pops and compares
// whenever the controller writes the state register or pulses done.
// A second instance with NR=14 covers the largest round count.
// Honours AES_ROUND_CTRL_DECRYPT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int NR     = 10;
    localparam int NR_BIG = 14;

    typedef struct packed {
        logic [3:0] round;
        logic [3:0] keyIdx;
        logic       loadIn;
        logic       subEn;
        logic       mixEn;
        logic       inv;
    } step_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;
    bit   idleNext = 1'b0;

    step_t stepQ[$];
    int    doneQ[$];
    int    stallPlan[NR+1];

    aes_round_ctrl_if bus ();
    aes_round_ctrl_if bus14 ();

    aes_round_ctrl #(.NR(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    aes_round_ctrl #(.NR(NR_BIG)) dut14 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus14)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Cycle index: inputs driven just after a rising edge and outputs sampled
    // on the following falling edge both see the same number.
    always @(posedge clk) cycle <= cycle + 1;

    // One write of the state register as the block description implies:
    // step 0 loads the input, steps 1..NR-1 are full rounds, step NR skips
    // mixcolumns. Decrypt walks the key schedule from NR down to 0.
    function automatic step_t modelStep(input int k, input bit mode);
        step_t s;
        bit    m;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
        m = mode;
`else
        m = 1'b0;
`endif
        s.round  = 4'(k);
        s.keyIdx = m ? 4'(NR - k) : 4'(k);
        s.loadIn = (k == 0);
        s.subEn  = (k != 0);
        s.mixEn  = (k != 0) && (k != NR);
        s.inv    = m;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearPlan();
        for (int k = 0; k <= NR; k++) stallPlan[k] = 0;
    endtask

    // Issue one block in the current (IDLE) cycle. Step k is preceded by
    // stallPlan[k] cycles without a round key. Returns in the IDLE cycle
    // that follows done.
    task automatic applyStimulus(input bit mode);
        int c0;
        int stallSum;
        c0       = cycle;
        stallSum = 0;
        for (int k = 0; k <= NR; k++) begin
            stepQ.push_back(modelStep(k, mode));
            stallSum += stallPlan[k];
        end
        doneQ.push_back(c0 + 1 + stallSum + NR + 1);
        bus.start     = 1'b1;
        bus.decrypt   = mode;
        bus.key_valid = 1'($urandom);
        tick();
        for (int k = 0; k <= NR; k++) begin
            for (int s = 0; s < stallPlan[k]; s++) begin
                bus.key_valid = 1'b0;
                bus.start     = 1'($urandom);
                bus.decrypt   = 1'($urandom);
                tick();
            end
            bus.key_valid = 1'b1;
            bus.start     = 1'($urandom);
            bus.decrypt   = 1'($urandom);
            tick();
        end
        bus.key_valid = 1'($urandom);
        bus.start     = 1'($urandom);
        tick();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.start     = 1'b0;
            bus.key_valid = 1'($urandom);
            bus.decrypt   = 1'($urandom);
            tick();
        end
    endtask

    // Start a block with keys always present and reset it abortAt cycles
    // after acceptance; the writes after the reset and its done never happen.
    task automatic abortBlock(input int abortAt);
        for (int k = 0; k <= NR; k++) stepQ.push_back(modelStep(k, 1'b1));
        bus.start     = 1'b1;
        bus.decrypt   = 1'b1;
        bus.key_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < abortAt; i++) tick();
        rst_n = 1'b0;
        tick();
        stepQ.delete();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("busy after reset", bus.busy, 1'b0);
        checkOutput("outputs after reset",
                    {bus.round, bus.key_idx, bus.load_in, bus.sub_en, bus.mix_en,
                     bus.state_we, bus.inv, bus.done}, '0);
        @(posedge clk);
        #1;
    endtask

    // Largest round count with keys always present: done 16 cycles after
    // the accepting cycle, and the final round shows round 14.
    task automatic bigTest();
        int c0;
        int doneAt;
        int maxRound;
        c0       = cycle;
        doneAt   = -1;
        maxRound = 0;
        bus14.start = 1'b1;
        tick();
        bus14.start = 1'b0;
        for (int n = 1; (n <= 40) && (doneAt < 0); n++) begin
            @(negedge clk);
            if (int'(bus14.round) > maxRound) maxRound = int'(bus14.round);
            if (bus14.sub_en && !bus14.mix_en)
                checkOutput("NR14 final round", bus14.round, 4'd14);
            if (bus14.done) doneAt = cycle - c0;
            @(posedge clk);
            #1;
        end
        checkOutput("NR14 done latency", doneAt, 16);
        checkOutput("NR14 max round", maxRound, 14);
    endtask

    // Monitor: outputs must all be 0 whenever the controller is idle; every
    // state-register write consumes the next expected step; every done
    // consumes the next expected completion cycle and must be followed by
    // exactly one idle cycle's worth of busy low.
    always @(negedge clk) begin : monitor
        step_t      got;
        step_t      want;
        logic [13:0] allOut;
        got    = {bus.round, bus.key_idx, bus.load_in, bus.sub_en, bus.mix_en, bus.inv};
        allOut = {got, bus.done, bus.state_we};
        if (!bus.busy) checkOutput("idle outputs zero", allOut, '0);
        if (idleNext) begin
            checkOutput("busy low after done", bus.busy, 1'b0);
            idleNext = 1'b0;
        end
        if (bus.state_we) begin
            if (stepQ.size() == 0) begin
                checkOutput("spurious state_we", bus.state_we, 1'b0);
            end else begin
                want = stepQ.pop_front();
                checkOutput("step fields", got, want);
                checkOutput("busy during step", bus.busy, 1'b1);
            end
        end
        if (bus.done) begin
            if (doneQ.size() == 0) begin
                checkOutput("spurious done", bus.done, 1'b0);
            end else begin
                checkOutput("done cycle", cycle, doneQ.pop_front());
            end
            checkOutput("state_we in done", bus.state_we, 1'b0);
            idleNext = 1'b1;
        end
    end

    // Main sequence: reset, directed blocks, randomized blocks, abort by
    // reset, recovery, then the NR=14 instance.
    initial begin
        bus.start       = 1'b0;
        bus.decrypt     = 1'b0;
        bus.key_valid   = 1'b0;
        bus14.start     = 1'b0;
        bus14.decrypt   = 1'b0;
        bus14.key_valid = 1'b1;
        rst_n           = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        clearPlan();
        applyStimulus(1'b0);
        idleCycles(1);
        clearPlan();
        applyStimulus(1'b1);
        idleCycles(2);
        clearPlan();
        stallPlan[4] = 3;
        applyStimulus(1'b0);
        clearPlan();
        applyStimulus(1'b1);

        for (int b = 0; b < 40; b++) begin
            for (int k = 0; k <= NR; k++)
                stallPlan[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            applyStimulus(1'($urandom));
            idleCycles(int'($urandom_range(0, 2)));
        end

        idleCycles(1);
        abortBlock(7);
        idleCycles(NR + 5);
        clearPlan();
        applyStimulus(1'b0);
        idleCycles(2);

        bigTest();
        idleCycles(2);

        checkOutput("steps drained", stepQ.size(), 0);
        checkOutput("dones drained", doneQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
